compa_arb: RTL and testbench
============================

Name: compa_arb

Overview:
- Shares one `compa` magnitude comparator instance among NREQ requesters.
- Each requester presents an operand pair (a, b). The arbiter grants requests round-robin and registers the operands into the shared comparator.
- It returns the registered {l,e,g} result tagged with the requester ID over a valid/ready response channel.
- Sits between compute clients and the comparator datapath; also keeps a saturating count of completed compares.

Parameters:
- NREQ, 4, number of requesters; power of 2, range 2..8; IDW = log2(NREQ), local.
- W, 2, operand width per requester.
- CNTW, 8, width of the completed-compare counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  NREQ  per-requester request; held high with operands stable until its gnt bit pulses.
- a_in  input  NREQ*W  packed operand a; requester i uses bits [i*W +: W].
- b_in  input  NREQ*W  packed operand b; same packing as a_in.
- gnt  output  NREQ  one-hot, combinational; a high bit means that requester's operands are captured at this edge.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result when rsp_valid && rsp_ready at an edge.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_leg  output  3  {l,e,g}; exactly one bit set while rsp_valid=1.
- busy  output  1  high in CMP or HOLD.
- done_cnt  output  CNTW  number of accepted responses; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, rr_ptr=0, op_a=op_b=0, op_id=0.
  - rsp_valid=0, rsp_id=0, rsp_leg=3'b000, done_cnt=0.
  - gnt forced to 0 while rst_n=0.
  - A reset mid-operation discards any in-flight compare or held result. No response is produced for it and done_cnt does not count it.
- Shared comparator: instance of `compa` with a=op_a, b=op_b. Outputs map to {l,e,g}: l=(a<b), e=(a==b), g=(a>b), unsigned W-bit compare.
- Round-robin arbitration:
  - Search req starting at index rr_ptr, ascending, wrapping at NREQ-1 to 0; the first set bit wins.
  - On a grant to winner w, rr_ptr <= (w+1) mod NREQ.
  - rr_ptr changes only on a grant.
- State machine:
  - IDLE:
    - gnt = onehot(winner) when req!=0, else 0.
    - On a grant: op_a, op_b, op_id <= winner's operands and index; go to CMP.
  - CMP:
    - gnt=0; the comparator evaluates.
    - At the edge: rsp_leg <= {l,e,g}, rsp_id <= op_id, rsp_valid <= 1; go to HOLD.
  - HOLD:
    - rsp_valid=1; rsp_leg and rsp_id stay stable until accepted.
    - rsp_valid && !rsp_ready: gnt=0, stay in HOLD. This is backpressure; no new grants.
    - rsp_ready=1 and req==0: rsp_valid <= 0, done_cnt++; go to IDLE.
    - rsp_ready=1 and req!=0 (simultaneous event): response accepted, done_cnt++, new grant issued in the same cycle (gnt driven, operands captured); go to CMP. rsp_valid <= 0.
- Timing:
  - Latency: gnt cycle T gives rsp_valid=1 at T+2.
  - Peak throughput is one compare per 2 cycles, with rsp_ready tied high and requests continuous.
- Requester rules:
  - req may drop only after its gnt.
  - A req deasserted before grant is simply not considered.
  - Operand changes while req is high and not yet granted are allowed; operands are sampled only at the grant edge.
- done_cnt:
  - Increments on each rsp_valid && rsp_ready edge.
  - Holds at 2^CNTW-1.
- busy = (state != IDLE).

Test Plan:
1. Single request: reset, then req=4'b0001, a=3, b=1 → gnt=0001 for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_leg=3'b001; done_cnt=1 after ready.
2. Round robin: req=4'b1111 held, each requester re-asserting after its grant, rsp_ready=1 → grant order 0,1,2,3,0; one grant every 2 cycles; rsp_id follows the same sequence.
3. Backpressure: result pending, rsp_ready=0 for 5 cycles with req=0010 → rsp_valid, rsp_leg and rsp_id stable; gnt=0 throughout. rsp_ready=1 → gnt=0010 in the same cycle; done_cnt increments once.
4. Equal and less-than: a=2, b=2 → rsp_leg=010; a=0, b=3 → rsp_leg=100; the grant-to-valid latency of 2 cycles holds in both.
5. Reset mid-operation: assert rst_n=0 in CMP, then in HOLD → next cycle rsp_valid=0, busy=0, done_cnt=0, rr_ptr=0. A subsequent req=1010 grants requester 1 first.
6. Saturation: CNTW=2, complete 5 compares → done_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/compa_arb.sv
// rtl/compa_arb.sv - round-robin arbiter sharing one magnitude comparator among NREQ requesters

// Unsigned W-bit magnitude comparator; exactly one of l/e/g is high.
module compa #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         l,
  output logic         e,
  output logic         g
);

  assign l = (a < b);
  assign e = (a == b);
  assign g = (a > b);

endmodule

module compa_arb #(
  parameter int NREQ = 4,
  parameter int W    = 2,
  parameter int CNTW = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*W-1:0]             a_in,
  input  logic [NREQ*W-1:0]             b_in,
  output logic [NREQ-1:0]               gnt,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [2:0]                    rsp_leg,
  output logic                          busy,
  output logic [CNTW-1:0]               done_cnt
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] rr_ptr;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [IDW-1:0] op_id;
  logic [IDW-1:0] winner;
  logic           found;
  logic           grant;
  logic           accept;
  logic           cmp_l;
  logic           cmp_e;
  logic           cmp_g;

  compa #(.W(W)) u_compa (
    .a (op_a),
    .b (op_b),
    .l (cmp_l),
    .e (cmp_e),
    .g (cmp_g)
  );

  // Round-robin search: first set req bit at or after rr_ptr, wrapping (NREQ is a power of 2).
  always_comb begin
    logic [IDW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and grant decision; a grant is also allowed on the accept edge of HOLD.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant   = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          if (found) begin
            grant   = 1'b1;
            state_d = CMP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!rst_n) begin
      grant = 1'b0;
    end
  end

  assign gnt    = grant ? (NREQ'(1) << winner) : '0;
  assign accept = rsp_valid && rsp_ready;
  assign busy   = (state_q != IDLE);

  // State, operand capture, response registers and saturating completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_leg   <= 3'b000;
      done_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        op_a   <= a_in[int'(winner)*W +: W];
        op_b   <= b_in[int'(winner)*W +: W];
        op_id  <= winner;
        rr_ptr <= winner + IDW'(1);
      end
      if (state_q == CMP) begin
        rsp_leg   <= {cmp_l, cmp_e, cmp_g};
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      if (accept) begin
        rsp_valid <= 1'b0;
        if (done_cnt != {CNTW{1'b1}}) begin
          done_cnt <= done_cnt + CNTW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_compa_arb.sv
// tb/tb_compa_arb.sv - directed and randomized self-checking bench for compa_arb

module tb_compa_arb;

  localparam int NREQ = 4;
  localparam int W    = 2;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req;
  logic [7:0]      a_in;
  logic [7:0]      b_in;
  logic            rsp_ready;
  logic [3:0]      gnt;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [2:0]      rsp_leg;
  logic            busy;
  logic [7:0]      done_cnt;
  logic [3:0]      gnt_s;
  logic            rsp_valid_s;
  logic [1:0]      rsp_id_s;
  logic [2:0]      rsp_leg_s;
  logic            busy_s;
  logic [1:0]      done_cnt_s;

  compa_arb #(.NREQ(NREQ), .W(W), .CNTW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_leg   (rsp_leg),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  compa_arb #(.NREQ(NREQ), .W(W), .CNTW(2)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt_s),
    .rsp_valid (rsp_valid_s),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id_s),
    .rsp_leg   (rsp_leg_s),
    .busy      (busy_s),
    .done_cnt  (done_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = waiting, 1 = comparing, 2 = result held
  int         m_phase;
  int         m_ptr;
  int         m_a;
  int         m_b;
  int         m_id;
  int         m_cnt;
  logic       e_valid;
  logic [1:0] e_id;
  logic [2:0] e_leg;
  logic [3:0] e_gnt;
  int         grants_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_a = 0; m_b = 0; m_id = 0; m_cnt = 0;
    e_valid = 1'b0; e_id = 2'd0; e_leg = 3'b000;
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, advance the model for the next rising edge.
  task automatic step(input logic rn, input logic [3:0] rq, input logic rdy,
                      input logic [7:0] av, input logic [7:0] bv);
    int  w;
    bit  can_grant;
    @(negedge clk);
    rst_n     = rn;
    req       = rq;
    rsp_ready = rdy;
    a_in      = av;
    b_in      = bv;
    #1;
    w = -1;
    can_grant = rn && ((m_phase == 0) || (m_phase == 2 && rdy));
    if (can_grant) begin
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && rq[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
    end
    e_gnt = (w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
    chk("rsp_id", 32'(rsp_id), 32'(e_id));
    chk("rsp_leg", 32'(rsp_leg), 32'(e_leg));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
    chk("done_cnt_sat", 32'(done_cnt_s), 32'((m_cnt > 3) ? 3 : m_cnt));
    if (w >= 0) grants_seen++;
    if (!rn) begin
      model_reset();
    end else begin
      if (m_phase == 2 && rdy) begin
        m_cnt++;
        e_valid = 1'b0;
        m_phase = 0;
      end else if (m_phase == 1) begin
        e_valid = 1'b1;
        e_id    = 2'(m_id);
        e_leg   = (m_a < m_b) ? 3'b100 : ((m_a == m_b) ? 3'b010 : 3'b001);
        m_phase = 2;
      end
      if (w >= 0) begin
        m_a     = (av >> (w * W)) & 3;
        m_b     = (bv >> (w * W)) & 3;
        m_id    = w;
        m_ptr   = (w + 1) % NREQ;
        m_phase = 1;
      end
    end
  endtask

  initial begin
    logic [3:0] rq;
    rst_n = 1'b0; req = '0; rsp_ready = 1'b0; a_in = '0; b_in = '0;
    grants_seen = 0;
    model_reset();
    e_gnt = '0;

    // reset
    step(1'b0, 4'b0000, 1'b0, 8'h00, 8'h00);
    step(1'b0, 4'b0000, 1'b0, 8'h00, 8'h00);

    // single request a=3 b=1 from requester 0
    step(1'b1, 4'b0001, 1'b1, 8'h03, 8'h01);
    repeat (3) step(1'b1, 4'b0000, 1'b1, 8'h00, 8'h00);

    // all requesters held, continuous ready: rotation 0..3
    repeat (12) step(1'b1, 4'b1111, 1'b1, 8'($urandom), 8'($urandom));
    repeat (3) step(1'b1, 4'b0000, 1'b1, 8'h00, 8'h00);

    // backpressure with requester 1 waiting
    step(1'b1, 4'b0001, 1'b0, 8'h02, 8'h01);
    repeat (6) step(1'b1, 4'b0010, 1'b0, 8'h0C, 8'h04);
    step(1'b1, 4'b0010, 1'b1, 8'h0C, 8'h04);
    repeat (3) step(1'b1, 4'b0000, 1'b1, 8'h00, 8'h00);

    // equal and less-than
    step(1'b1, 4'b0001, 1'b1, 8'h02, 8'h02);
    repeat (3) step(1'b1, 4'b0000, 1'b1, 8'h00, 8'h00);
    step(1'b1, 4'b0001, 1'b1, 8'h00, 8'h03);
    repeat (3) step(1'b1, 4'b0000, 1'b1, 8'h00, 8'h00);

    // reset during compare, then during held result
    step(1'b1, 4'b0100, 1'b0, 8'h30, 8'h10);
    step(1'b0, 4'b0000, 1'b0, 8'h00, 8'h00);
    step(1'b1, 4'b1010, 1'b1, 8'h84, 8'h48);
    step(1'b1, 4'b0000, 1'b0, 8'h00, 8'h00);
    step(1'b1, 4'b0000, 1'b0, 8'h00, 8'h00);
    step(1'b0, 4'b0000, 1'b0, 8'h00, 8'h00);
    step(1'b1, 4'b1010, 1'b1, 8'h48, 8'h84);
    repeat (3) step(1'b1, 4'b0000, 1'b1, 8'h00, 8'h00);

    // randomized traffic, random backpressure and occasional reset
    rq = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] raise;
      logic [3:0] keep;
      raise = 4'($urandom);
      keep  = 4'($urandom);
      rq = (rq & ~(e_gnt & ~keep)) | (raise & 4'($urandom));
      step(($urandom_range(0, 59) != 0), rq, ($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom));
    end

    // long saturation run on the narrow counter
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 4'b0001, 1'b1, 8'($urandom), 8'($urandom));
      step(1'b1, 4'b0000, 1'b1, 8'h00, 8'h00);
      step(1'b1, 4'b0000, 1'b1, 8'h00, 8'h00);
    end

    checks++;
    assert (grants_seen > 50) else begin
      errors++;
      $error("FAIL grant_activity observed=%0d expected=>50", grants_seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
